// File: rtl/arith_pckg.sv
// Arithmetic configuration shared by the fixed-point datapath blocks.
package arith_pckg;

    typedef struct packed {
        int unsigned word_wdt;
        int unsigned frac_wdt;
    } arith_cfg_t;

    localparam arith_cfg_t C_ADD_ARITH_CFG = '{word_wdt: 16, frac_wdt: 8};

endpackage

// File: rtl/proc_pipe_pckg.sv
// Pipeline data element shared along the accumulator lanes, its reset value
// and the default adder stage counts.
package proc_pipe_pckg;

    import arith_pckg::*;

    localparam int unsigned C_WORD_WDT = C_ADD_ARITH_CFG.word_wdt;
    localparam int unsigned C_TYPE_WDT = 2;

    typedef enum logic [C_TYPE_WDT-1:0] {
        TYPE_DATA     = 2'd0,
        TYPE_ACC_BIAS = 2'd1,
        TYPE_ACC_CLR  = 2'd2,
        TYPE_CTRL     = 2'd3
    } data_type_e;

    typedef struct packed {
        logic [C_WORD_WDT-1:0] data_word;
        logic                  data_val;
        logic                  data_last;
        data_type_e            data_type;
    } pipe_data_t;

    localparam int unsigned C_PIPE_DATA_WDT = $bits(pipe_data_t);

    localparam pipe_data_t C_PIPE_DATA_RST_VAL = '{
        data_word: '0,
        data_val:  1'b0,
        data_last: 1'b0,
        data_type: TYPE_DATA
    };

    localparam int unsigned C_ADD_FXP_IN_CYC_LEN  = 1;
    localparam int unsigned C_ADD_FXP_OUT_CYC_LEN = 1;

endpackage

// File: rtl/del_chain.sv
// Parametric delay chain of LEN registers that advance only on clk_en and
// load RST_VAL (which clears the carried valid bit) on synchronous reset.
module del_chain #(
    parameter int unsigned      LEN     = 1,
    parameter int unsigned      WDT     = 8,
    parameter logic [WDT-1:0]   RST_VAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic [WDT-1:0] din,
    output logic [WDT-1:0] dout
);

    if (LEN == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, clk_en};
        assign dout = din;
    end else begin : g_regs
        logic [LEN-1:0][WDT-1:0] stage_q;
        logic [LEN-1:0][WDT-1:0] stage_d;

        // Whole chain shifts together so a stall never drops or doubles data.
        always_comb begin
            stage_d = stage_q;
            if (clk_en) begin
                stage_d[0] = din;
                for (int unsigned i = 1; i < LEN; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i < LEN; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[LEN-1];
    end

endmodule

// File: rtl/add_wrapper.sv
// One-lane pipelined fixed-point adder: sum of both words, side-channel from B.
// Build option ADD_WRAPP_SAT_EN selects saturating instead of wrapping overflow.
module add_wrapper
    import arith_pckg::*;
    import proc_pipe_pckg::*;
#(
    parameter arith_cfg_t  ADD_ARITH_CFG   = C_ADD_ARITH_CFG,
    parameter int unsigned ADD_IN_CYC_LEN  = C_ADD_FXP_IN_CYC_LEN,
    parameter int unsigned ADD_OUT_CYC_LEN = C_ADD_FXP_OUT_CYC_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  pipe_data_t add_op_a,
    input  pipe_data_t add_op_b,
    output pipe_data_t add_res
);

    localparam int unsigned W = ADD_ARITH_CFG.word_wdt;
    localparam logic [2*C_PIPE_DATA_WDT-1:0] C_IN_RST_VAL =
        {C_PIPE_DATA_RST_VAL, C_PIPE_DATA_RST_VAL};

    logic [2*C_PIPE_DATA_WDT-1:0] in_chain_din;
    logic [2*C_PIPE_DATA_WDT-1:0] in_chain_dout;
    pipe_data_t                   op_a_s;
    pipe_data_t                   op_b_s;
    logic [W:0]                   sum_ext;
    logic [W-1:0]                 sum_word;
    pipe_data_t                   sum_res;
    logic [C_PIPE_DATA_WDT-1:0]   out_chain_dout;

    assign in_chain_din = {add_op_a, add_op_b};

    del_chain #(
        .LEN     (ADD_IN_CYC_LEN),
        .WDT     (2*C_PIPE_DATA_WDT),
        .RST_VAL (C_IN_RST_VAL)
    ) u_in_chain (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .din    (in_chain_din),
        .dout   (in_chain_dout)
    );

    assign {op_a_s, op_b_s} = in_chain_dout;

    // One guard bit: overflow shows as disagreement between the top two bits.
    always_comb begin
        sum_ext  = {op_a_s.data_word[W-1], op_a_s.data_word}
                 + {op_b_s.data_word[W-1], op_b_s.data_word};
        sum_word = sum_ext[W-1:0];
`ifdef ADD_WRAPP_SAT_EN
        if (sum_ext[W] != sum_ext[W-1]) begin
            sum_word = sum_ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        sum_res           = op_b_s;
        sum_res.data_word = op_b_s.data_val ? sum_word : '0;
    end

    del_chain #(
        .LEN     (ADD_OUT_CYC_LEN),
        .WDT     (C_PIPE_DATA_WDT),
        .RST_VAL (C_PIPE_DATA_RST_VAL)
    ) u_out_chain (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .din    (sum_res),
        .dout   (out_chain_dout)
    );

    assign add_res = pipe_data_t'(out_chain_dout);

endmodule

// File: tb/tb_add_wrapper.sv
// Directed bench for add_wrapper: a 1+1 stage instance and a zero-latency instance.
module tb_add_wrapper;

    import arith_pckg::*;
    import proc_pipe_pckg::*;

`ifdef ADD_WRAPP_SAT_EN
    localparam logic [15:0] EXP_OVF_POS = 16'h7FFF;
    localparam logic [15:0] EXP_OVF_NEG = 16'h8000;
`else
    localparam logic [15:0] EXP_OVF_POS = 16'h8000;
    localparam logic [15:0] EXP_OVF_NEG = 16'h7FFF;
`endif

    logic       clk;
    logic       rst;
    logic       clk_en;
    pipe_data_t op_a;
    pipe_data_t op_b;
    pipe_data_t res;
    pipe_data_t op_a0;
    pipe_data_t op_b0;
    pipe_data_t res0;

    int checks;
    int errors;

    add_wrapper #(
        .ADD_ARITH_CFG   (C_ADD_ARITH_CFG),
        .ADD_IN_CYC_LEN  (1),
        .ADD_OUT_CYC_LEN (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .add_op_a (op_a),
        .add_op_b (op_b),
        .add_res  (res)
    );

    add_wrapper #(
        .ADD_ARITH_CFG   (C_ADD_ARITH_CFG),
        .ADD_IN_CYC_LEN  (0),
        .ADD_OUT_CYC_LEN (0)
    ) dut0 (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .add_op_a (op_a0),
        .add_op_b (op_b0),
        .add_res  (res0)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic pipe_data_t mk(input logic [15:0] w, input logic v,
                                      input logic l, input data_type_e t);
        pipe_data_t p;
        p.data_word = w;
        p.data_val  = v;
        p.data_last = l;
        p.data_type = t;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        op_a = mk(16'h0, 1'b0, 1'b0, TYPE_DATA);
        op_b = mk(16'h0, 1'b0, 1'b0, TYPE_DATA);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk_en = 1'b1;
        drive_idle();
        op_a0 = mk(16'h0, 1'b0, 1'b0, TYPE_DATA);
        op_b0 = mk(16'h0, 1'b0, 1'b0, TYPE_DATA);
        step();
        step();
        rst = 1'b0;
        checks++;
        if (res !== C_PIPE_DATA_RST_VAL) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", res, C_PIPE_DATA_RST_VAL);
        end
        step();
        checks++;
        if (res !== C_PIPE_DATA_RST_VAL) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", res, C_PIPE_DATA_RST_VAL);
        end
    endtask

    task automatic test_latency();
        op_a = mk(16'h0003, 1'b0, 1'b0, TYPE_DATA);
        op_b = mk(16'h0005, 1'b1, 1'b1, TYPE_DATA);
        step();
        drive_idle();
        checks++;
        if (res.data_val !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got val %b expected 0", res.data_val);
        end
        step();
        checks++;
        if (res !== mk(16'h0008, 1'b1, 1'b1, TYPE_DATA)) begin
            errors++;
            $display("FAIL latency_hit: got %h expected %h", res, mk(16'h0008, 1'b1, 1'b1, TYPE_DATA));
        end
        step();
        checks++;
        if (res.data_val !== 1'b0) begin
            errors++;
            $display("FAIL latency_late: got val %b expected 0", res.data_val);
        end
    endtask

    task automatic test_overflow();
        op_a = mk(16'h7FFF, 1'b1, 1'b0, TYPE_DATA);
        op_b = mk(16'h0001, 1'b1, 1'b0, TYPE_DATA);
        step();
        op_a = mk(16'h8000, 1'b1, 1'b0, TYPE_DATA);
        op_b = mk(16'hFFFF, 1'b1, 1'b0, TYPE_DATA);
        step();
        drive_idle();
        checks++;
        if (res !== mk(EXP_OVF_POS, 1'b1, 1'b0, TYPE_DATA)) begin
            errors++;
            $display("FAIL overflow_pos: got %h expected word %h", res, EXP_OVF_POS);
        end
        step();
        checks++;
        if (res !== mk(EXP_OVF_NEG, 1'b1, 1'b0, TYPE_DATA)) begin
            errors++;
            $display("FAIL overflow_neg: got %h expected word %h", res, EXP_OVF_NEG);
        end
        step();
    endtask

    task automatic test_stall();
        pipe_data_t exp_hold;
        exp_hold = mk(16'd11, 1'b1, 1'b0, TYPE_DATA);
        op_a = mk(16'd10, 1'b1, 1'b0, TYPE_DATA);
        op_b = mk(16'd1, 1'b1, 1'b0, TYPE_DATA);
        step();
        op_b = mk(16'd2, 1'b1, 1'b0, TYPE_DATA);
        step();
        checks++;
        if (res !== exp_hold) begin
            errors++;
            $display("FAIL stall_first: got %h expected %h", res, exp_hold);
        end
        op_b = mk(16'd3, 1'b1, 1'b0, TYPE_DATA);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (res !== exp_hold) begin
                errors++;
                $display("FAIL stall_hold%0d: got %h expected %h", i, res, exp_hold);
            end
        end
        clk_en = 1'b1;
        step();
        drive_idle();
        checks++;
        if (res !== mk(16'd12, 1'b1, 1'b0, TYPE_DATA)) begin
            errors++;
            $display("FAIL stall_second: got %h expected word 000c val 1", res);
        end
        step();
        checks++;
        if (res !== mk(16'd13, 1'b1, 1'b0, TYPE_DATA)) begin
            errors++;
            $display("FAIL stall_third: got %h expected word 000d val 1", res);
        end
        step();
        checks++;
        if (res.data_val !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: got val %b expected 0", res.data_val);
        end
    endtask

    task automatic test_side_channel();
        op_a = mk(16'h0000, 1'b0, 1'b0, TYPE_DATA);
        op_b = mk(16'h0042, 1'b1, 1'b0, TYPE_ACC_BIAS);
        step();
        op_a = mk(16'h0005, 1'b1, 1'b0, TYPE_DATA);
        op_b = mk(16'h0007, 1'b0, 1'b1, TYPE_ACC_BIAS);
        step();
        drive_idle();
        checks++;
        if (res !== mk(16'h0042, 1'b1, 1'b0, TYPE_ACC_BIAS)) begin
            errors++;
            $display("FAIL side_from_b: got %h expected %h", res, mk(16'h0042, 1'b1, 1'b0, TYPE_ACC_BIAS));
        end
        step();
        checks++;
        if (res !== mk(16'h0000, 1'b0, 1'b1, TYPE_ACC_BIAS)) begin
            errors++;
            $display("FAIL side_b_invalid: got %h expected %h", res, mk(16'h0000, 1'b0, 1'b1, TYPE_ACC_BIAS));
        end
        step();
    endtask

    task automatic test_reset_mid();
        op_a = mk(16'h0001, 1'b1, 1'b0, TYPE_DATA);
        op_b = mk(16'h0002, 1'b1, 1'b0, TYPE_DATA);
        step();
        op_b = mk(16'h0004, 1'b1, 1'b1, TYPE_ACC_BIAS);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_idle();
        checks++;
        if (res !== C_PIPE_DATA_RST_VAL) begin
            errors++;
            $display("FAIL reset_mid_flush: got %h expected %h", res, C_PIPE_DATA_RST_VAL);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (res.data_val !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_late%0d: got val %b expected 0", i, res.data_val);
            end
        end
    endtask

    task automatic test_zero_latency();
        op_a0 = mk(16'h0010, 1'b1, 1'b0, TYPE_DATA);
        op_b0 = mk(16'h0020, 1'b1, 1'b1, TYPE_DATA);
        #1;
        checks++;
        if (res0 !== mk(16'h0030, 1'b1, 1'b1, TYPE_DATA)) begin
            errors++;
            $display("FAIL zero_lat_sum: got %h expected %h", res0, mk(16'h0030, 1'b1, 1'b1, TYPE_DATA));
        end
        clk_en = 1'b0;
        op_a0 = mk(16'h7FFF, 1'b1, 1'b0, TYPE_DATA);
        op_b0 = mk(16'h0001, 1'b1, 1'b0, TYPE_ACC_CLR);
        #1;
        checks++;
        if (res0 !== mk(EXP_OVF_POS, 1'b1, 1'b0, TYPE_ACC_CLR)) begin
            errors++;
            $display("FAIL zero_lat_stalled: got %h expected word %h", res0, EXP_OVF_POS);
        end
        clk_en = 1'b1;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_latency();
        test_overflow();
        test_stall();
        test_side_channel();
        test_reset_mid();
        test_zero_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
